// File: rtl/dec_stream_if.sv
// dec_stream_if: start-value input handshake plus countdown output stream (in/in_valid/in_ready, out/out_valid/out_ready/out_last/out_idx)
interface dec_stream_if #(parameter int width = 8);
  logic [width-1:0] in;
  logic in_valid;
  logic in_ready;
  logic [width-1:0] out;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic [width-1:0] out_idx;
  modport master(output in, in_valid, out_ready, input in_ready, out, out_valid, out_last, out_idx);
  modport slave(input in, in_valid, out_ready, output in_ready, out, out_valid, out_last, out_idx);
endinterface

// File: rtl/dec_stream.sv
// dec_stream: accepts a start value on s.in, then streams it down by step per accepted beat until below step (clk, sync active-low rst_n, s slave port)
module dec_stream #(
  parameter int width = 8,
  parameter int step = 1
) (
  input logic clk,
  input logic rst_n,
  dec_stream_if.slave s
);
  localparam logic [0:0] idle = 1'b0;
  localparam logic [0:0] run = 1'b1;
  localparam logic [width-1:0] stp = width'(step);
  logic [0:0] state_q, state_d;
  logic [width-1:0] cur_q, cur_d, idx_q, idx_d;
  logic last, acc, adv;
  always_comb begin
    last = state_q == run && (stp == '0 || cur_q < stp);
    acc = state_q == idle && s.in_valid;
    adv = state_q == run && s.out_ready;
    state_d = acc ? run : (adv && last) ? idle : state_q;
    cur_d = acc ? s.in : (adv && !last) ? cur_q - stp : cur_q;
    idx_d = acc ? '0 : (adv && !last) ? idx_q + width'(1) : idx_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= idle;
      cur_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      idx_q <= idx_d;
    end
  end
  assign s.in_ready = state_q == idle;
  assign s.out_valid = state_q == run;
  assign s.out = cur_q;
  assign s.out_idx = idx_q;
  assign s.out_last = last;
endmodule

// File: tb/tb_dec_stream.sv
// tb_dec_stream: scoreboard bench driving four dec_stream configurations through one shared stimulus path
module tb_dec_stream;
  logic clk = 0;
  logic rst_n = 0;
  logic [7:0] din = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  int sel = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] o_out, o_idx;
  logic o_valid, o_last, o_inrdy;
  typedef struct {logic [7:0] v; logic [7:0] i; logic l;} beat_t;
  beat_t q[$];
  int wid[4] = '{8, 4, 8, 8};
  int stp[4] = '{3, 7, 0, 1};
  always #5 clk = ~clk;
  dec_stream_if #(.width(8)) i0 ();
  dec_stream_if #(.width(4)) i1 ();
  dec_stream_if #(.width(8)) i2 ();
  dec_stream_if #(.width(8)) i3 ();
  assign i0.in = din;
  assign i1.in = din[3:0];
  assign i2.in = din;
  assign i3.in = din;
  assign i0.in_valid = in_valid && sel == 0;
  assign i1.in_valid = in_valid && sel == 1;
  assign i2.in_valid = in_valid && sel == 2;
  assign i3.in_valid = in_valid && sel == 3;
  assign i0.out_ready = out_ready;
  assign i1.out_ready = out_ready;
  assign i2.out_ready = out_ready;
  assign i3.out_ready = out_ready;
  dec_stream #(.width(8), .step(3)) u0 (.clk(clk), .rst_n(rst_n), .s(i0));
  dec_stream #(.width(4), .step(7)) u1 (.clk(clk), .rst_n(rst_n), .s(i1));
  dec_stream #(.width(8), .step(0)) u2 (.clk(clk), .rst_n(rst_n), .s(i2));
  dec_stream #(.width(8), .step(1)) u3 (.clk(clk), .rst_n(rst_n), .s(i3));
  always_comb begin
    o_out = i0.out;
    o_idx = i0.out_idx;
    o_valid = i0.out_valid;
    o_last = i0.out_last;
    o_inrdy = i0.in_ready;
    case (sel)
      1: begin
        o_out = {4'b0, i1.out};
        o_idx = {4'b0, i1.out_idx};
        o_valid = i1.out_valid;
        o_last = i1.out_last;
        o_inrdy = i1.in_ready;
      end
      2: begin
        o_out = i2.out;
        o_idx = i2.out_idx;
        o_valid = i2.out_valid;
        o_last = i2.out_last;
        o_inrdy = i2.in_ready;
      end
      3: begin
        o_out = i3.out;
        o_idx = i3.out_idx;
        o_valid = i3.out_valid;
        o_last = i3.out_last;
        o_inrdy = i3.in_ready;
      end
      default: ;
    endcase
  end

  task automatic expect_run(input int k, input int start);
    int mask = (1 << wid[k]) - 1;
    int st = stp[k] & mask;
    int cur = start & mask;
    int idx = 0;
    bit last = 0;
    while (!last) begin
      last = st == 0 || cur < st;
      q.push_back('{v: 8'(cur), i: 8'(idx), l: last});
      if (!last) begin
        cur = cur - st;
        idx = (idx + 1) & mask;
      end
    end
  endtask

  task automatic run_stream(input int k, input int start, input int stall_at, input int stall_n, input int stall_pct, input string name);
    int beat = 0;
    int held = 0;
    int guard = 0;
    @(posedge clk);
    #1;
    sel = k;
    out_ready = 0;
    q.delete();
    expect_run(k, start);
    @(negedge clk);
    n_checks++;
    if ({o_inrdy, o_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s idle_before: in_ready,out_valid=%b%b expected 10", name, o_inrdy, o_valid);
    end
    din = 8'(start);
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    while (q.size() > 0 && guard < 2000) begin
      guard++;
      if (beat == stall_at && held < stall_n) begin
        out_ready = 0;
        held++;
      end else out_ready = stall_pct == 0 || $urandom_range(99) >= stall_pct;
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1 || {o_out, o_idx, o_last} !== {q[0].v, q[0].i, q[0].l}) begin
        n_fail++;
        $display("FAIL %s beat%0d: valid=%b out=%0d idx=%0d last=%b expected valid=1 out=%0d idx=%0d last=%b",
                 name, beat, o_valid, o_out, o_idx, o_last, q[0].v, q[0].i, q[0].l);
      end
      if (out_ready) begin
        void'(q.pop_front());
        beat++;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 0;
    if (guard >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: %0d beats left expected 0", name, q.size());
    end
    @(negedge clk);
    n_checks++;
    if ({o_inrdy, o_valid, o_last} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s idle_after: in_ready,out_valid,out_last=%b%b%b expected 100", name, o_inrdy, o_valid, o_last);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    din = 8'd99;
    in_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      n_checks++;
      if ({o_inrdy, o_valid, o_out, o_last, o_idx} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
        n_fail++;
        $display("FAIL reset_in k%0d: rdy=%b valid=%b out=%0d last=%b idx=%0d expected 1 0 0 0 0", k, o_inrdy, o_valid, o_out, o_last, o_idx);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    in_valid = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      n_checks++;
      if ({o_inrdy, o_valid, o_out, o_last, o_idx} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
        n_fail++;
        $display("FAIL reset_after k%0d: rdy=%b valid=%b out=%0d last=%b idx=%0d expected 1 0 0 0 0", k, o_inrdy, o_valid, o_out, o_last, o_idx);
      end
    end
  endtask

  task automatic test_seq();
    run_stream(0, 10, -1, 0, 0, "w8s3_10");
  endtask

  task automatic test_narrow();
    run_stream(1, 15, -1, 0, 0, "w4s7_15");
    run_stream(3, 0, -1, 0, 0, "s1_zero");
    run_stream(0, 255, -1, 0, 0, "w8s3_255");
  endtask

  task automatic test_step0();
    run_stream(2, 200, -1, 0, 0, "s0_200");
  endtask

  task automatic test_backpressure();
    run_stream(3, 5, 1, 3, 0, "s1_stall");
  endtask

  task automatic test_mid_reset();
    @(posedge clk);
    #1;
    sel = 0;
    din = 8'd10;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_out, o_idx} !== {1'b1, 8'd10, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_b0: valid=%b out=%0d idx=%0d expected 1 10 0", o_valid, o_out, o_idx);
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_out, o_idx} !== {1'b1, 8'd7, 8'd1}) begin
      n_fail++;
      $display("FAIL mid_reset_b1: valid=%b out=%0d idx=%0d expected 1 7 1", o_valid, o_out, o_idx);
    end
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({o_inrdy, o_valid, o_out, o_idx} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
        n_fail++;
        $display("FAIL mid_reset_c%0d: rdy=%b valid=%b out=%0d idx=%0d expected 1 0 0 0", c, o_inrdy, o_valid, o_out, o_idx);
      end
      @(negedge clk);
    end
    out_ready = 0;
    run_stream(0, 2, -1, 0, 0, "after_reset_2");
  endtask

  task automatic test_random();
    for (int r = 0; r < 24; r++) begin
      int k = $urandom_range(3);
      int start = (k == 3) ? $urandom_range(40) : $urandom_range(255);
      run_stream(k, start, $urandom_range(4), $urandom_range(3), 30, $sformatf("rand%0d_k%0d_%0d", r, k, start));
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_narrow();
    test_step0();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
